// File: rtl/ts_packet_framer.sv
// ts_packet_framer
//
// Acquires MPEG-2 188-byte packet alignment on a raw TS byte stream and paces
// it into 204-byte output slots for the randomizer/RS chain. Each slot carries
// the sync byte (flagged by oPSync), then 187 payload bytes, then 16 zeroed
// check-byte slots (flagged by oCheck) that the RS encoder overwrites.
//
// Optional feature: define NULL_FILL_EN to emit null packets (47 1F FF 10,
// FF x184, 16 check slots) whenever a slot-0 request finds no locked input.
// With NULL_FILL_EN undefined, nothing is emitted in that case and the slot
// counter holds at 0.
//
// Parameters:
//   SYNC_LOCK  consecutive 0x47 bytes at 188-byte spacing to declare lock (2..7)
//   SYNC_LOSS  consecutive missing sync bytes in lock before re-hunting (1..7)
//
// Ports:
//   iClk    clock
//   iRst    asynchronous active-high reset
//   iData   input TS byte
//   iValid  iData valid
//   oReady  combinational; byte consumed when iValid && oReady
//   iEn     downstream byte-slot request (at most one byte emitted per iEn)
//   oData   output byte (registered, one cycle after the emitting iEn)
//   oValid  oData valid
//   oPSync  oValid byte is slot 0 of a 204-byte slot
//   oCheck  oValid byte is a zeroed check byte (slots 188..203), oData = 0
//   oLock   acquisition FSM is in LOCK

module ts_packet_framer #(
  parameter int SYNC_LOCK = 3,
  parameter int SYNC_LOSS = 3
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  input  logic       iEn,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oPSync,
  output logic       oCheck,
  output logic       oLock
);

  localparam logic [7:0] SYNC_BYTE    = 8'h47;
  localparam logic [7:0] LAST_PAYLOAD = 8'd187;
  localparam logic [7:0] LAST_SLOT    = 8'd203;
  localparam logic [2:0] GOOD_LAST    = 3'(SYNC_LOCK - 1);
  localparam logic [2:0] MISS_LAST    = 3'(SYNC_LOSS - 1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCK
  } acqState_t;

  acqState_t  stateReg, stateNext;
  logic [7:0] hCntReg, hCntNext;     // bytes consumed since the last accepted sync
  logic [2:0] goodReg, goodNext;     // syncs seen at correct spacing while verifying
  logic [2:0] missReg, missNext;     // consecutive bad sync bytes while locked
  logic [7:0] slotReg, slotNext;     // output slot position 0..203
  logic       srcPktReg, srcPktNext; // current output slot carries source data (vs null)

  logic       ready;
  logic       emit;
  logic [7:0] emitData;
  logic       emitPSync;
  logic       emitCheck;
  logic       headIsSync;

  // Null packet body: PID 0x1FFF header, then stuffing.
  function automatic logic [7:0] nullByte(input logic [7:0] slot);
    case (slot)
      8'd0:    nullByte = SYNC_BYTE;
      8'd1:    nullByte = 8'h1F;
      8'd2:    nullByte = 8'hFF;
      8'd3:    nullByte = 8'h10;
      default: nullByte = 8'hFF;
    endcase
  endfunction

  assign headIsSync = (iData == SYNC_BYTE);
  assign oReady     = ready & ~iRst;

  always_comb begin
    stateNext  = stateReg;
    hCntNext   = hCntReg;
    goodNext   = goodReg;
    missNext   = missReg;
    slotNext   = slotReg;
    srcPktNext = srcPktReg;
    ready      = 1'b0;
    emit       = 1'b0;
    emitData   = 8'h00;
    emitPSync  = 1'b0;
    emitCheck  = 1'b0;

    // Acquisition: every byte is pulled through while hunting/verifying.
    unique case (stateReg)
      HUNT: begin
        ready = 1'b1;
        if (iValid && headIsSync) begin
          stateNext = VERIFY;
          hCntNext  = 8'd0;
          goodNext  = 3'd1;
        end
      end
      VERIFY: begin
        if (hCntReg != LAST_PAYLOAD) begin
          ready = 1'b1;
          if (iValid) hCntNext = hCntReg + 8'd1;
        end else begin
          // The final confirming sync is left at the head so it becomes the
          // first byte of the first forwarded packet.
          ready = (goodReg != GOOD_LAST);
          if (iValid) begin
            if (!headIsSync) begin
              stateNext = HUNT;
              goodNext  = 3'd0;
              hCntNext  = 8'd0;
            end else if (goodReg == GOOD_LAST) begin
              stateNext = LOCK;
              missNext  = 3'd0;
            end else begin
              goodNext = goodReg + 3'd1;
              hCntNext = 8'd0;
            end
          end
        end
      end
      LOCK: ; // handled by the slot logic below
      default: stateNext = HUNT;
    endcase

    // Output slot pacing.
    if (iEn) begin
      if (slotReg == 8'd0) begin
        if (stateReg == LOCK && iValid) begin
          if (headIsSync || missReg != MISS_LAST) begin
            // A bad sync is flywheeled: the byte is consumed and 0x47 emitted.
            ready      = 1'b1;
            emit       = 1'b1;
            emitData   = SYNC_BYTE;
            emitPSync  = 1'b1;
            srcPktNext = 1'b1;
            missNext   = headIsSync ? 3'd0 : missReg + 3'd1;
          end else begin
            stateNext = HUNT;
            missNext  = 3'd0;
            goodNext  = 3'd0;
            hCntNext  = 8'd0;
          end
        end else begin
`ifdef NULL_FILL_EN
          emit       = 1'b1;
          emitData   = SYNC_BYTE;
          emitPSync  = 1'b1;
          srcPktNext = 1'b0;
`else
          // No packet to start: nothing emitted, slot holds at 0.
`endif
        end
      end else if (slotReg <= LAST_PAYLOAD) begin
        if (srcPktReg) begin
          // Source packets only exist in LOCK; an input gap holds the slot.
          ready = 1'b1;
          if (iValid) begin
            emit     = 1'b1;
            emitData = iData;
          end
        end else begin
          emit     = 1'b1;
          emitData = nullByte(slotReg);
        end
      end else begin
        emit      = 1'b1;
        emitCheck = 1'b1;
      end
    end

    if (emit) slotNext = (slotReg == LAST_SLOT) ? 8'd0 : slotReg + 8'd1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateReg  <= HUNT;
      hCntReg   <= 8'd0;
      goodReg   <= 3'd0;
      missReg   <= 3'd0;
      slotReg   <= 8'd0;
      srcPktReg <= 1'b0;
      oData     <= 8'h00;
      oValid    <= 1'b0;
      oPSync    <= 1'b0;
      oCheck    <= 1'b0;
      oLock     <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      hCntReg   <= hCntNext;
      goodReg   <= goodNext;
      missReg   <= missNext;
      slotReg   <= slotNext;
      srcPktReg <= srcPktNext;
      oData     <= emitData;
      oValid    <= emit;
      oPSync    <= emitPSync;
      oCheck    <= emitCheck;
      oLock     <= (stateNext == LOCK);
    end
  end

endmodule

// File: tb/tb_ts_packet_framer.sv
// Testbench for ts_packet_framer (SYNC_LOCK = 3, SYNC_LOSS = 3).
// Stimulus feeds an input byte queue (negative entries are one-cycle input
// gaps); expected output bytes are queued as stimulus is issued and a
// separate negedge monitor pops and compares them as the DUT emits.

module tb_ts_packet_framer;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iData;
  logic       iValid;
  logic       oReady;
  logic       iEn;
  logic [7:0] oData;
  logic       oValid;
  logic       oPSync;
  logic       oCheck;
  logic       oLock;

  typedef struct packed {
    logic [7:0] data;
    logic       pSync;
    logic       chk;
    logic       lock;
  } exp_t;

  exp_t expQ[$];
  int   inQ[$];
  int   total = 0;
  int   bad   = 0;
  logic prevEn = 1'b0;
  bit   altMode = 1'b0;
  bit   enPhase = 1'b0;
  bit   enOn = 1'b0;

  always #5 iClk = ~iClk;

  ts_packet_framer #(.SYNC_LOCK(3), .SYNC_LOSS(3)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iData (iData),
    .iValid(iValid),
    .oReady(oReady),
    .iEn   (iEn),
    .oData (oData),
    .oValid(oValid),
    .oPSync(oPSync),
    .oCheck(oCheck),
    .oLock (oLock)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // iEn as seen by the DUT on the most recent rising edge.
  always @(posedge iClk) prevEn <= iEn;

  // Monitor: every emitted byte must match the head of the expected queue.
  always @(negedge iClk) begin
    exp_t e;
    if (oValid === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %02h psync=%0b check=%0b, expected no output at %0t",
                 oData, oPSync, oCheck, $time);
      end else begin
        e = expQ.pop_front();
        check("byte_data", 32'(oData), 32'(e.data));
        check("byte_psync", 32'(oPSync), 32'(e.pSync));
        check("byte_check", 32'(oCheck), 32'(e.chk));
        check("byte_lock", 32'(oLock), 32'(e.lock));
      end
    end else if (altMode && prevEn && expQ.size() > 0) begin
      check("en_emit", 32'(oValid), 32'd1);
    end
    if (!prevEn) check("idle_valid", 32'(oValid), 32'd0);
  end

  // One clock of stimulus; entered and left at negedge + 1.
  task automatic step();
    bit take;
    bit gap;
    gap    = (inQ.size() > 0) && (inQ[0] < 0);
    iValid = (inQ.size() > 0) && !gap;
    iData  = 8'h00;
    if (iValid) iData = 8'(inQ[0]);
    iEn     = enOn && (altMode ? enPhase : 1'b1);
    enPhase = ~enPhase;
    #1;
    take = iValid && oReady;
    if (altMode && take) check("take_on_en", 32'(iEn), 32'd1);
    @(posedge iClk);
    if (take || gap) void'(inQ.pop_front());
    @(negedge iClk);
    #1;
    if (gap) check("gap_quiet", 32'(oValid), 32'd0);
  endtask

  task automatic runUntilIn(input int left, input string name);
    int n;
    n = 0;
    while (inQ.size() > left && n < 5000) begin
      step();
      n++;
    end
    check(name, 32'(inQ.size() <= left), 32'd1);
  endtask

  task automatic drainExp(input string name);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 5000) begin
      step();
      n++;
    end
    check(name, 32'(expQ.size()), 32'd0);
  endtask

  // Input packet: sync byte then payload 1..187, optional gap before byte gapAt.
  task automatic inPkt(input logic [7:0] sync, input int gapAt, input int gapLen);
    inQ.push_back(int'(sync));
    for (int i = 1; i <= 187; i++) begin
      if (i == gapAt) for (int g = 0; g < gapLen; g++) inQ.push_back(-1);
      inQ.push_back(i);
    end
  endtask

  // Expected first `count` slots of a 204-byte output slot sequence.
  task automatic expSlots(input bit isNull, input int count, input logic lk);
    exp_t e;
    for (int s = 0; s < count; s++) begin
      e.lock  = lk;
      e.pSync = (s == 0);
      e.chk   = (s >= 188);
      if (s == 0)        e.data = 8'h47;
      else if (s >= 188) e.data = 8'h00;
      else if (!isNull)  e.data = 8'(s);
      else if (s == 1)   e.data = 8'h1F;
      else if (s == 3)   e.data = 8'h10;
      else               e.data = 8'hFF;
      expQ.push_back(e);
    end
  endtask

  task automatic pulseReset();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
  endtask

  initial begin
    iRst   = 1'b1;
    iEn    = 1'b0;
    iValid = 1'b0;
    iData  = 8'h00;
    @(negedge iClk);
    #1;
    // Reset state, with a valid sync byte offered.
    iValid = 1'b1;
    iData  = 8'h47;
    iEn    = 1'b1;
    #1;
    check("rst_ready", 32'(oReady), 32'd0);
    @(posedge iClk);
    @(negedge iClk);
    #1;
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_data", 32'(oData), 32'd0);
    check("rst_psync", 32'(oPSync), 32'd0);
    check("rst_check", 32'(oCheck), 32'd0);
    check("rst_lock", 32'(oLock), 32'd0);
    iRst   = 1'b0;
    iValid = 1'b0;
    iEn    = 1'b0;
    enOn   = 1'b1;

`ifdef NULL_FILL_EN
    // No input, continuous slot requests: repeating null packets, unlocked.
    expSlots(1'b1, 204, 1'b0);
    expSlots(1'b1, 204, 1'b0);
    drainExp("null_fill");
    check("null_lock", 32'(oLock), 32'd0);
`else
    // Acquisition on three clean packets; 4th has a 5-cycle gap at slot 50.
    inPkt(8'h47, 0, 0);
    inPkt(8'h47, 0, 0);
    inPkt(8'h47, 0, 0);
    inPkt(8'h47, 50, 5);
    expSlots(1'b0, 204, 1'b1);
    expSlots(1'b0, 204, 1'b1);
    runUntilIn(457, "verify_wait");
    check("lock_verify", 32'(oLock), 32'd0);
    drainExp("pkts_3_4");
    check("lock_held", 32'(oLock), 32'd1);
    check("gap_no_loss", 32'(inQ.size()), 32'd0);

    // iEn every second cycle while locked.
    inPkt(8'h47, 0, 0);
    expSlots(1'b0, 204, 1'b1);
    altMode = 1'b1;
    drainExp("alt_pkt");
    altMode = 1'b0;

    // Three bad syncs: two flywheeled, third drops lock with no output.
    inPkt(8'h00, 0, 0);
    inPkt(8'h00, 0, 0);
    inPkt(8'h00, 0, 0);
    expSlots(1'b0, 204, 1'b1);
    expSlots(1'b0, 204, 1'b1);
    drainExp("flywheel");
    runUntilIn(0, "loss_drain");
    for (int i = 0; i < 3; i++) step();
    check("loss_unlock", 32'(oLock), 32'd0);

    // Reset at slot 100 of a forwarded packet, then fresh reacquisition.
    pulseReset();
    for (int p = 0; p < 4; p++) inPkt(8'h47, 0, 0);
    expSlots(1'b0, 204, 1'b1);
    expSlots(1'b0, 100, 1'b1);
    runUntilIn(88, "to_slot100");
    check("pre_rst_exp", 32'(expQ.size()), 32'd0);
    iRst = 1'b1;
    step();
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_data", 32'(oData), 32'd0);
    check("midrst_psync", 32'(oPSync), 32'd0);
    check("midrst_check", 32'(oCheck), 32'd0);
    check("midrst_lock", 32'(oLock), 32'd0);
    check("midrst_ready", 32'(oReady), 32'd0);
    inQ.delete();
    iRst = 1'b0;
    for (int p = 0; p < 3; p++) inPkt(8'h47, 0, 0);
    expSlots(1'b0, 204, 1'b1);
    drainExp("reacq");
    check("reacq_lock", 32'(oLock), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
